seq_alu: RTL

- Parametrised, multi-cycle successor to the combinational 6-bit alu_top.
- Add/sub complete in one cycle. Signed multiply (shift-add) and signed divide (restoring, magnitude-based) iterate over WIDTH cycles.
- start/busy/done handshake, so it can sit behind a controller or bench that issues one operation at a time.
- Encodings are unchanged from alu_top: func 00 add, 01 sub, 10 mul, 11 div.

---
 rtl/seq_alu.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Brief    : Multi-cycle signed ALU. Add/sub in one cycle; shift-add multiply
//             and restoring divide over WIDTH iterations, start/busy/done.
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         func,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic               overflow,
    output logic               div_by_zero
);
    localparam int                 c_cnt_w   = $clog2(WIDTH + 1);
    localparam logic [1:0]         c_st_idle = 2'd0;
    localparam logic [1:0]         c_st_run  = 2'd1;
    localparam logic [1:0]         c_st_fix  = 2'd2;
    localparam logic [WIDTH-1:0]   c_min     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_b_zero;
    logic               r_ovf_case;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH:0]     r_opnd;
    logic [WIDTH:0]     r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic [2*WIDTH-1:0] r_out;
    logic               r_ovf;
    logic               r_dbz;

    logic               w_accept;
    logic [WIDTH:0]     w_a_ext;
    logic [WIDTH:0]     w_b_ext;
    logic [WIDTH:0]     w_a_mag;
    logic [WIDTH:0]     w_b_mag;
    logic [WIDTH-1:0]   w_as_res;
    logic               w_as_ovf;
    logic [WIDTH+1:0]   w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH+1:0]   w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_div_res;

    assign w_accept = (r_state == c_st_idle) && start;

    // One extra bit so that the magnitude of the most negative value fits.
    assign w_a_ext = {a[WIDTH-1], a};
    assign w_b_ext = {b[WIDTH-1], b};
    assign w_a_mag = a[WIDTH-1] ? -w_a_ext : w_a_ext;
    assign w_b_mag = b[WIDTH-1] ? -w_b_ext : w_b_ext;

    assign w_as_res = func[0] ? (a - b) : (a + b);
    assign w_as_ovf = func[0]
                    ? ((a[WIDTH-1] != b[WIDTH-1]) && (w_as_res[WIDTH-1] != a[WIDTH-1]))
                    : ((a[WIDTH-1] == b[WIDTH-1]) && (w_as_res[WIDTH-1] != a[WIDTH-1]));

    // Multiply: r_hi accumulates, r_lo holds the multiplier and collects low product bits.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+2){1'b0}});

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_div_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {1'b0, r_opnd};
    assign w_div_ge    = !w_div_diff[WIDTH+1];

    assign w_prod    = {r_hi[WIDTH-1:0], r_lo};
    assign w_mul_res = r_neg_res ? -w_prod : w_prod;
    assign w_quo     = r_neg_res ? -r_lo : r_lo;
    assign w_rem     = r_neg_rem ? -r_hi[WIDTH-1:0] : r_hi[WIDTH-1:0];
    assign w_div_res = r_b_zero ? {{WIDTH{1'b1}}, r_a_raw} : {w_quo, w_rem};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (start && func[1]) w_state_next = c_st_run;
            c_st_run:  if (r_cnt == c_last)  w_state_next = c_st_fix;
            c_st_fix:  w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (r_state != c_st_idle) busy = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_b_zero   <= 1'b0;
            r_ovf_case <= 1'b0;
            r_a_raw    <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_out      <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                if (!func[1]) begin
                    r_out  <= {{WIDTH{w_as_res[WIDTH-1]}}, w_as_res};
                    r_ovf  <= w_as_ovf;
                    r_dbz  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_is_div   <= func[0];
                    r_neg_res  <= a[WIDTH-1] ^ b[WIDTH-1];
                    r_neg_rem  <= a[WIDTH-1];
                    r_b_zero   <= (b == '0);
                    r_ovf_case <= (a == c_min) && (b == '1);
                    r_a_raw    <= a;
                    r_cnt      <= '0;
                    r_hi       <= '0;
                    if (func[0]) begin
                        r_lo   <= w_a_mag[WIDTH-1:0];
                        r_opnd <= w_b_mag;
                    end else begin
                        r_lo   <= w_b_mag[WIDTH-1:0];
                        r_opnd <= w_a_mag;
                    end
                end
            end else if (r_state == c_st_run) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
                if (r_is_div) begin
                    r_hi <= w_div_ge ? w_div_diff[WIDTH:0] : w_div_shift;
                    r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
                end else begin
                    r_hi <= w_mul_sum[WIDTH+1:1];
                    r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                end
            end else if (r_state == c_st_fix) begin
                r_out  <= r_is_div ? w_div_res : w_mul_res;
                r_ovf  <= r_is_div && r_ovf_case;
                r_dbz  <= r_is_div && r_b_zero;
                r_done <= 1'b1;
            end
        end
    end

    assign done        = r_done;
    assign out         = r_out;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
